// File: rtl/cirno_pkg.sv
// -----------------------------------------------------------------------------
// cirno_pkg
// Shared types and constants for the Cirno 8-bit control sequencer.
//   ctrl_state_t : sequencer state encoding
//   CLS_*        : instruction class, IR[7:6]
//   FN_*         : function of the misc class, IR[5:4]
//   alu_op_t     : ALU operation, IR[5:4] of the ALU class
//   inst_kind_t  : one-hot decoded instruction kind
// -----------------------------------------------------------------------------
package cirno_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } ctrl_state_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LDHI = 2'b01;
  localparam logic [1:0] CLS_LDLO = 2'b10;
  localparam logic [1:0] CLS_MISC = 2'b11;

  localparam logic [1:0] FN_MOV  = 2'b00;
  localparam logic [1:0] FN_LD   = 2'b01;
  localparam logic [1:0] FN_ST   = 2'b10;
  localparam logic [1:0] FN_HALT = 2'b11;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic alu;
    logic ldhi;
    logic ldlo;
    logic mov;
    logic ld;
    logic st;
    logic halt;
  } inst_kind_t;

endpackage

// File: rtl/cirno_ctrl_if.sv
// -----------------------------------------------------------------------------
// cirno_ctrl_if
// Bundle of every signal between the Cirno sequencer and its responders.
//   master : the sequencer (drives pc, selects, enables, requests)
//   slave  : the responder side (drives inst, inst_ack, mem_ack)
// Fetch handshake : pc, inst_req, inst_ack, inst
// Register file   : r1, r2, immediate, reg_*_en, y_is_imm
// ALU             : alu_op
// Data memory     : mem_req, mem_we, mem_ack
// Status          : halted, fault
// -----------------------------------------------------------------------------
interface cirno_ctrl_if;
  import cirno_pkg::*;

  logic [7:0] pc;
  logic       inst_req;
  logic       inst_ack;
  logic [7:0] inst;

  logic [1:0] r1;
  logic [1:0] r2;
  logic [5:0] immediate;
  logic       reg_readx_en;
  logic       reg_ready_en;
  logic       reg_r_en;
  logic       reg_w_en;
  logic       reg_hi_en;
  logic       reg_lo_en;
  logic       reg_swap_en;
  logic       y_is_imm;
  logic       reg_mem_w_en;

  alu_op_t    alu_op;

  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;

  logic       halted;
  logic       fault;

  modport master (
    output pc, inst_req, r1, r2, immediate,
           reg_readx_en, reg_ready_en, reg_r_en, reg_w_en,
           reg_hi_en, reg_lo_en, reg_swap_en, y_is_imm, reg_mem_w_en,
           alu_op, mem_req, mem_we, halted, fault,
    input  inst_ack, inst, mem_ack
  );

  modport slave (
    input  pc, inst_req, r1, r2, immediate,
           reg_readx_en, reg_ready_en, reg_r_en, reg_w_en,
           reg_hi_en, reg_lo_en, reg_swap_en, y_is_imm, reg_mem_w_en,
           alu_op, mem_req, mem_we, halted, fault,
    output inst_ack, inst, mem_ack
  );

endinterface

// File: rtl/cirno_ctrl_decode.sv
// -----------------------------------------------------------------------------
// cirno_ctrl_decode
// Purely combinational instruction decode of the instruction register.
//   ir        in  8 : instruction register
//   kind      out   : one-hot instruction kind
//   op        out 2 : ALU operation field IR[5:4]
//   r1, r2    out 2 : register selects (LDHI/LDLO take r1 from IR[5:4])
//   immediate out 6 : zero-extended IR[3:0]
// -----------------------------------------------------------------------------
module cirno_ctrl_decode
  import cirno_pkg::*;
(
  input  logic [7:0] ir,
  output inst_kind_t kind,
  output alu_op_t    op,
  output logic [1:0] r1,
  output logic [1:0] r2,
  output logic [5:0] immediate
);

  logic [1:0] cls;
  logic [1:0] fn;

  assign cls = ir[7:6];
  assign fn  = ir[5:4];

  always_comb begin
    kind = '0;
    case (cls)
      CLS_ALU:  kind.alu  = 1'b1;
      CLS_LDHI: kind.ldhi = 1'b1;
      CLS_LDLO: kind.ldlo = 1'b1;
      default: begin
        case (fn)
          FN_MOV:  kind.mov  = 1'b1;
          FN_LD:   kind.ld   = 1'b1;
          FN_ST:   kind.st   = 1'b1;
          default: kind.halt = 1'b1;
        endcase
      end
    endcase
  end

  assign op        = alu_op_t'(fn);
  // Nibble loads have no second register operand, so their target moves up
  // into the field the other classes use for the function code.
  assign r1        = (cls == CLS_LDHI || cls == CLS_LDLO) ? ir[5:4] : ir[3:2];
  assign r2        = ir[1:0];
  assign immediate = {2'b00, ir[3:0]};

endmodule

// File: rtl/cirno_ctrl.sv
// -----------------------------------------------------------------------------
// cirno_ctrl
// Multi-cycle control sequencer for the Cirno 8-bit core. Fetches over a
// request/ack handshake, decodes, and drives the register file, ALU op and
// data-memory handshake. Owns pc and the instruction register.
//   clk   in  1 : rising-edge clock
//   reset in  1 : asynchronous, active-high
//   bus   master modport of cirno_ctrl_if (fetch, regfile, ALU, memory, status)
// Parameter TIMEOUT : handshake wait limit in cycles (timeout build only).
// Optional feature: define CIRNO_MEM_TIMEOUT_EN to abort a handshake that is
// not acked within TIMEOUT cycles, setting sticky fault and halting. Without
// it handshakes wait forever and fault is tied to 0.
// -----------------------------------------------------------------------------
module cirno_ctrl
  import cirno_pkg::*;
#(
  parameter int TIMEOUT = 15
)(
  input  logic  clk,
  input  logic  reset,
  cirno_ctrl_if.master bus
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic [7:0]  pc;
  logic [7:0]  ir;
  logic        timeout_hit;
  logic        fault;

  inst_kind_t  kind;
  alu_op_t     dec_op;
  logic [1:0]  dec_r1;
  logic [1:0]  dec_r2;
  logic [5:0]  dec_imm;

  cirno_ctrl_decode u_decode (
    .ir        (ir),
    .kind      (kind),
    .op        (dec_op),
    .r1        (dec_r1),
    .r2        (dec_r2),
    .immediate (dec_imm)
  );

  assign bus.pc        = pc;
  assign bus.r1        = dec_r1;
  assign bus.r2        = dec_r2;
  assign bus.immediate = dec_imm;
  assign bus.fault     = fault;

  // Next state and all strobes; everything depends on state and IR only.
  always_comb begin
    state_nxt        = state;
    bus.inst_req     = 1'b0;
    bus.reg_readx_en = 1'b0;
    bus.reg_ready_en = 1'b0;
    bus.reg_r_en     = 1'b0;
    bus.reg_w_en     = 1'b0;
    bus.reg_hi_en    = 1'b0;
    bus.reg_lo_en    = 1'b0;
    bus.reg_swap_en  = 1'b0;
    bus.y_is_imm     = 1'b0;
    bus.reg_mem_w_en = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.halted       = 1'b0;

    case (state)
      ST_IDLE: state_nxt = ST_FETCH;

      ST_FETCH: begin
        bus.inst_req = 1'b1;
        if (bus.inst_ack)  state_nxt = ST_DECODE;
        else if (timeout_hit) state_nxt = ST_HALT;
      end

      ST_DECODE: begin
        if (kind.halt)                       state_nxt = ST_HALT;
        else if (kind.alu || kind.ld || kind.st) state_nxt = ST_READ;
        else                                 state_nxt = ST_WB;
      end

      ST_READ: begin
        bus.reg_r_en     = 1'b1;
        bus.reg_readx_en = kind.alu || kind.st;
        bus.reg_ready_en = kind.alu || kind.ld || kind.st;
        state_nxt        = kind.alu ? ST_EXEC : ST_MEM;
      end

      ST_EXEC: begin
        bus.alu_op = dec_op;
        state_nxt  = ST_WB;
      end

      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = kind.st;
        // A store is finished once memory accepts it; no write-back needed.
        if (bus.mem_ack)      state_nxt = kind.st ? ST_FETCH : ST_WB;
        else if (timeout_hit) state_nxt = ST_HALT;
      end

      ST_WB: begin
        bus.reg_w_en     = kind.alu;
        bus.alu_op       = kind.alu ? dec_op : ALU_ADD;
        bus.reg_hi_en    = kind.ldhi;
        bus.reg_lo_en    = kind.ldlo;
        bus.y_is_imm     = kind.ldhi || kind.ldlo;
        bus.reg_swap_en  = kind.mov;
        bus.reg_mem_w_en = kind.ld;
        state_nxt        = ST_FETCH;
      end

      ST_HALT: bus.halted = 1'b1;

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, pc and IR; pc advances on the same edge that captures IR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && bus.inst_ack) begin
        ir <= bus.inst;
        pc <= pc + 8'h01;
      end
    end
  end

`ifdef CIRNO_MEM_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [3:0] wait_cnt;
  logic       waiting;

  assign waiting     = (state == ST_FETCH && !bus.inst_ack) ||
                       (state == ST_MEM   && !bus.mem_ack);
  // The cycle that would be the TIMEOUT-th unacked one aborts the handshake.
  assign timeout_hit = waiting && (wait_cnt == WAIT_LAST);

  // Counter is zero whenever no handshake is waiting, so it starts clear on
  // every entry to FETCH or MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      fault    <= 1'b0;
    end else begin
      if (waiting && !timeout_hit) wait_cnt <= wait_cnt + 4'd1;
      else                         wait_cnt <= 4'd0;
      if (timeout_hit) fault <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

endmodule

// File: doc/cirno_ctrl.md
# cirno_ctrl

Multi-cycle control sequencer for the Cirno 8-bit core. Fetches instructions over a request/ack handshake, decodes them, and drives the register file's select/enable inputs, the ALU op, and the data-memory handshake. It is the initiator of every register-file access. It owns `pc` and the instruction register; the register file, ALU and memories are its responders.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum wait cycles on a memory handshake. Used only with `CIRNO_MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc` out 8: instruction address.
- `inst_req` out 1, `inst_ack` in 1, `inst` in 8: fetch handshake. `inst` is valid in the ack cycle.
- `r1`, `r2` out 2: register selects. `r1` = IR[3:2], `r2` = IR[1:0]; for LDHI/LDLO, `r1` = IR[5:4].
- `immediate` out 6: {2'b00, IR[3:0]}.
- `reg_readx_en`, `reg_ready_en`, `reg_r_en`, `reg_w_en`, `reg_hi_en`, `reg_lo_en`, `reg_swap_en`, `y_is_imm`, `reg_mem_w_en` out 1 each: register-file controls.
- `alu_op` out 2: 0 ADD, 1 SUB, 2 AND, 3 OR. Equals IR[5:4].
- `mem_req` out 1, `mem_we` out 1, `mem_ack` in 1: data-memory handshake. Address is y and store data is x, both taken from the register file.
- `halted` out 1, `fault` out 1.

## Operation
- ISA, IR[7:6] class:
  - 00 ALU: r1 <= r1 op r2.
  - 01 LDHI: r1[7:4] <= imm4.
  - 10 LDLO: r1[3:0] <= imm4.
  - 11 misc, IR[5:4]: 00 MOV (r1 <= r2), 01 LD (r1 <= M[r2]), 10 ST (M[r2] <= r1), 11 HALT.
- States: IDLE, FETCH, DECODE, READ, EXEC, MEM, WB, HALT.
- All outputs are a combinational function of state and IR. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state FETCH.
- FETCH: `inst_req`=1. On `inst_ack`: IR <= `inst`, `pc` <= `pc`+1 (wraps 8'hFF to 0), next DECODE. Otherwise stay.
- DECODE: no outputs.
  - ALU, LD, ST: next READ.
  - LDHI, LDLO, MOV: next WB.
  - HALT: next HALT.
- READ: `reg_r_en`=1.
  - `reg_readx_en`=1 for ALU and ST.
  - `reg_ready_en`=1 for ALU, LD and ST.
  - ALU: next EXEC. LD, ST: next MEM.
- EXEC: `alu_op` valid while x/y settle. Next WB.
- MEM: `mem_req`=1; `mem_we`=1 for ST. On `mem_ack`: LD goes to WB, ST goes to FETCH. Otherwise stay.
- WB, by class:
  - ALU: `reg_w_en`=1, `alu_op` held.
  - LDHI: `reg_hi_en`=1, `y_is_imm`=1.
  - LDLO: `reg_lo_en`=1, `y_is_imm`=1.
  - MOV: `reg_swap_en`=1.
  - LD: `reg_mem_w_en`=1. The memory holds `mem_out` stable from ack until its next request.
  - Next state FETCH.
- HALT: `halted`=1. Stays until `reset`.
- Acks that arrive outside FETCH/MEM are ignored. Exactly one register-write enable is ever asserted per cycle.

## Timing
- Reset: state IDLE, `pc`=0, IR=0, `fault`=0, all outputs 0. Reset mid-handshake drops the request; a late ack is ignored.
- Instruction latency with zero-wait acks (FETCH first to next FETCH):
  - ALU: 5 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - LDHI, LDLO, MOV: 3 cycles.
- Each wait cycle on a handshake adds one cycle.
- `pc` increments in the same edge that latches IR. It points at the next instruction from DECODE onward.

## Configuration
- `CIRNO_MEM_TIMEOUT_EN` defined:
  - A 4-bit wait counter clears on entry to FETCH/MEM and counts each unacked cycle.
  - If it reaches `TIMEOUT` without an ack: `fault` <= 1, request dropped, next HALT.
  - `fault` is sticky until `reset`.
- Undefined: handshakes wait indefinitely, `fault` is constant 0, and no counter is synthesized.

## Structure
- Package `cirno_pkg` holds:
  - state enum `ctrl_state_t`
  - class constants `CLS_ALU`/`CLS_LDHI`/`CLS_LDLO`/`CLS_MISC`
  - misc func constants
  - `alu_op_t`
- Sub-module `cirno_ctrl_decode`: combinational IR -> class, func, `r1`/`r2`/`immediate` fields. The FSM stays in `cirno_ctrl`.

## Test plan
- Reset, then `inst`=8'h4A (LDHI r0,0xA) with immediate ack -> IDLE, FETCH, DECODE, WB. `reg_hi_en` and `y_is_imm` high in WB, `immediate`=6'h0A, `r1`=0, `pc`=1.
- `inst`=8'h1B (SUB r2,r3) -> READ has `reg_r_en`/`reg_readx_en`/`reg_ready_en`=1. `alu_op`=1 in EXEC and WB. `reg_w_en` only in WB. 5 cycles.
- LD 8'hD6 with `mem_ack` delayed 3 cycles -> `mem_req`=1 for 4 cycles with `mem_we`=0, then `reg_mem_w_en` for one cycle. ST 8'hE6 -> `mem_we`=1, returns to FETCH with no register write.
- `pc`=8'hFF and fetch acked -> `pc`=0. HALT 8'hF0 -> `halted`=1 and no further `inst_req`.
- With `CIRNO_MEM_TIMEOUT_EN`, `inst_ack` held 0 -> `fault`=1 and HALT after 15 wait cycles. Without the macro, still waiting after 100 cycles with `fault`=0.
- `reset` asserted during MEM -> outputs 0 immediately. A subsequent `mem_ack` is ignored and the block refetches from `pc`=0.
